// File: rtl/ws2812_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 frame controller.
package ws2812_pkg;

    localparam int GRB_W = 24;

    localparam int DEF_NUM_LEDS = 16;
    localparam int DEF_T_BIT    = 63;
    localparam int DEF_T0H      = 20;
    localparam int DEF_T1H      = 40;
    localparam int DEF_T_RESET  = 4000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    // One counter serves both the bit period and the latch gap.
    function automatic int cyc_width(input int t_bit, input int t_reset);
        return $clog2(((t_bit > t_reset) ? t_bit : t_reset) + 1);
    endfunction

endpackage

// File: rtl/ws2812_frame_controller_if.sv
// Host-side register interface: pixel writes, frame requests and status.
interface ws2812_frame_controller_if #(
    parameter int ADDR_W = 4
);
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic [ws2812_pkg::GRB_W-1:0] wr_data;
    logic                         start;
    logic                         auto_refresh;
    logic                         busy;
    logic                         done;

    modport master (
        output wr_en, wr_addr, wr_data, start, auto_refresh,
        input  busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, auto_refresh,
        output busy, done
    );
endinterface

// File: rtl/ws2812_bit_encoder.sv
// Serialises one GRB word at a time into WS2812 high/low pulses and times the latch gap.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int T_BIT   = DEF_T_BIT,
    parameter int T0H     = DEF_T0H,
    parameter int T1H     = DEF_T1H,
    parameter int T_RESET = DEF_T_RESET
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  state_t           state_s,
    input  state_t           state_next_s,
    input  logic             load_s,
    input  logic [GRB_W-1:0] load_data_s,
    output logic             word_end_s,
    output logic             latch_end_s,
    output logic             dout
);

    localparam int CYC_W = cyc_width(T_BIT, T_RESET);
    localparam logic [CYC_W-1:0] BIT_LAST   = CYC_W'(T_BIT - 1);
    localparam logic [CYC_W-1:0] RESET_LAST = CYC_W'(T_RESET - 1);
    localparam logic [CYC_W-1:0] HIGH_0     = CYC_W'(T0H);
    localparam logic [CYC_W-1:0] HIGH_1     = CYC_W'(T1H);
    localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_ZERO   = {CYC_W{1'b0}};
    localparam logic [4:0]       BIT_TOP    = 5'(GRB_W - 1);

    logic [GRB_W-1:0] shreg_r, shreg_s;
    logic [4:0]       bit_idx_r, bit_idx_s;
    logic [CYC_W-1:0] cyc_r, cyc_s;
    logic             bit_end_s;
    logic             dout_r, dout_s;

    // Next shift/counter values; dout is registered from them so it tracks the FSM state exactly.
    always_comb begin
        bit_end_s   = (state_s == SEND) && (cyc_r == BIT_LAST);
        word_end_s  = bit_end_s && (bit_idx_r == 5'd0);
        latch_end_s = (state_s == LATCH) && (cyc_r == RESET_LAST);
        shreg_s     = shreg_r;
        bit_idx_s   = bit_idx_r;
        cyc_s       = cyc_r;

        if (load_s) begin
            shreg_s   = load_data_s;
            bit_idx_s = BIT_TOP;
        end else if (bit_end_s) begin
            shreg_s   = {shreg_r[GRB_W-2:0], 1'b0};
            bit_idx_s = (bit_idx_r == 5'd0) ? 5'd0 : (bit_idx_r - 5'd1);
        end else begin
            shreg_s   = shreg_r;
            bit_idx_s = bit_idx_r;
        end

        case (state_s)
            SEND:    cyc_s = bit_end_s   ? CYC_ZERO : (cyc_r + CYC_ONE);
            LATCH:   cyc_s = latch_end_s ? CYC_ZERO : (cyc_r + CYC_ONE);
            default: cyc_s = CYC_ZERO;
        endcase

        dout_s = (state_next_s == SEND) && (cyc_s < (shreg_s[GRB_W-1] ? HIGH_1 : HIGH_0));
    end

    // Encoder state registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            shreg_r   <= {GRB_W{1'b0}};
            bit_idx_r <= 5'd0;
            cyc_r     <= CYC_ZERO;
            dout_r    <= 1'b0;
        end else begin
            shreg_r   <= shreg_s;
            bit_idx_r <= bit_idx_s;
            cyc_r     <= cyc_s;
            dout_r    <= dout_s;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/ws2812_frame_controller.sv
// WS2812 frame controller: pixel buffer, frame FSM and start arbitration around the bit encoder.
module ws2812_frame_controller
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T_BIT    = DEF_T_BIT,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int T_RESET  = DEF_T_RESET,
    parameter int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    ws2812_frame_controller_if.slave   host,
    output logic                       dout
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W:0]   NUM_PIX  = (ADDR_W + 1)'(NUM_LEDS);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pix_idx_r, rd_idx_s;
    logic              pending_r, busy_r, done_r;
    logic [GRB_W-1:0]  pixel_r [NUM_LEDS];
    logic [GRB_W-1:0]  load_data_s;
    logic              last_pix_s, wr_ok_s, go_s, load_s;
    logic              word_end_s, latch_end_s;

    // Buffer read side: pixel 0 on LOAD, otherwise the pixel after the one on the wire.
    always_comb begin
        last_pix_s = (pix_idx_r == LAST_PIX);
        wr_ok_s    = host.wr_en && ({1'b0, host.wr_addr} < NUM_PIX);
        go_s       = pending_r || host.auto_refresh || host.start;
        load_s     = (state_r == LOAD) || (word_end_s && !last_pix_s);
        if ((state_r == LOAD) || last_pix_s) begin
            rd_idx_s = IDX_ZERO;
        end else begin
            rd_idx_s = pix_idx_r + IDX_ONE;
        end
        load_data_s = pixel_r[rd_idx_s];
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = (host.start || host.auto_refresh) ? LOAD : IDLE;
            LOAD:    state_s = SEND;
            SEND:    state_s = (word_end_s && last_pix_s) ? LATCH : SEND;
            LATCH: begin
                if (latch_end_s) begin
                    state_s = go_s ? LOAD : IDLE;
                end else begin
                    state_s = LATCH;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM, pixel index, pending request and registered status.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r   <= IDLE;
            pix_idx_r <= IDX_ZERO;
            pending_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= latch_end_s;
            if (state_r == LOAD) begin
                pix_idx_r <= IDX_ZERO;
            end else if (word_end_s && !last_pix_s) begin
                pix_idx_r <= pix_idx_r + IDX_ONE;
            end else begin
                pix_idx_r <= pix_idx_r;
            end
            // A start in the final latch cycle is served by go_s, so clearing here loses nothing.
            if (latch_end_s) begin
                pending_r <= 1'b0;
            end else if (host.start && (state_r != IDLE)) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Host pixel buffer writes.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                pixel_r[i] <= {GRB_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            pixel_r[host.wr_addr] <= host.wr_data;
        end else begin
            pixel_r <= pixel_r;
        end
    end

    assign host.busy = busy_r;
    assign host.done = done_r;

    ws2812_bit_encoder #(
        .T_BIT   (T_BIT),
        .T0H     (T0H),
        .T1H     (T1H),
        .T_RESET (T_RESET)
    ) u_encoder (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .state_s       (state_r),
        .state_next_s  (state_s),
        .load_s        (load_s),
        .load_data_s   (load_data_s),
        .word_end_s    (word_end_s),
        .latch_end_s   (latch_end_s),
        .dout          (dout)
    );

endmodule

// File: tb/tb_ws2812_frame_controller.sv
// Randomised bench for ws2812_frame_controller, checked every cycle against a frame-offset reference model.
module tb_ws2812_frame_controller;

    localparam int NL         = 2;
    localparam int AW         = 1;
    localparam int TB_T_BIT   = 10;
    localparam int TB_T0H     = 3;
    localparam int TB_T1H     = 7;
    localparam int TB_T_RESET = 20;
    localparam int PIX_LEN    = 24 * TB_T_BIT;
    localparam int SEND_LEN   = NL * PIX_LEN;
    localparam int LAST_T     = SEND_LEN + TB_T_RESET;

    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;
    logic dout;

    always #5 clk_clk = ~clk_clk;

    ws2812_frame_controller_if #(.ADDR_W(AW)) host_if ();

    ws2812_frame_controller #(
        .NUM_LEDS (NL),
        .T_BIT    (TB_T_BIT),
        .T0H      (TB_T0H),
        .T1H      (TB_T1H),
        .T_RESET  (TB_T_RESET)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .host          (host_if),
        .dout          (dout)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_done_seen = 0;

    // Reference model: frame activity as an offset t from LOAD entry (t = 0 .. LAST_T).
    bit          m_active;
    int          m_t;
    bit          m_pending;
    bit          m_done;
    logic [23:0] m_px    [NL];
    logic [23:0] m_frame [NL];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_t       = 0;
        m_pending = 1'b0;
        m_done    = 1'b0;
        for (int i = 0; i < NL; i++) begin
            m_px[i]    = 24'h0;
            m_frame[i] = 24'h0;
        end
    endtask

    function automatic logic exp_dout();
        int k, b, ph, p;
        logic v;
        if (!m_active || m_t < 1 || m_t > SEND_LEN) return 1'b0;
        k  = m_t - 1;
        b  = k / TB_T_BIT;
        ph = k % TB_T_BIT;
        p  = b / 24;
        v  = m_frame[p][23 - (b % 24)];
        return (ph < (v ? TB_T1H : TB_T0H));
    endfunction

    task automatic model_step(input logic st, input logic ar, input logic we, input int wa, input logic [23:0] wd);
        bit nd;
        if (m_active) begin
            for (int p = 0; p < NL; p++) begin
                if (m_t == p * PIX_LEN) m_frame[p] = m_px[p];
            end
        end
        nd = m_active && (m_t == LAST_T);
        if (m_active) begin
            if (m_t == LAST_T) begin
                if (m_pending || ar || st) m_t = 0;
                else m_active = 1'b0;
                m_pending = 1'b0;
            end else begin
                if (st) m_pending = 1'b1;
                m_t++;
            end
        end else if (st || ar) begin
            m_active = 1'b1;
            m_t      = 0;
        end
        if (we && wa < NL) m_px[wa] = wd;
        m_done = nd;
    endtask

    // Called at a falling edge: check this cycle, drive its inputs, advance model and clock.
    task automatic cycle(input logic st, input logic ar, input logic we, input int wa, input logic [23:0] wd);
        check_value("busy", host_if.busy, m_active);
        check_value("done", host_if.done, m_done);
        check_value("dout", dout, exp_dout());
        if (host_if.done === 1'b1) n_done_seen++;
        host_if.start        = st;
        host_if.auto_refresh = ar;
        host_if.wr_en        = we;
        host_if.wr_addr      = wa[AW-1:0];
        host_if.wr_data      = wd;
        model_step(st, ar, we, wa, wd);
        @(negedge clk_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 24'h0);
    endtask

    initial begin
        int   lat;
        int   d0;
        logic ar;
        host_if.start        = 1'b0;
        host_if.auto_refresh = 1'b0;
        host_if.wr_en        = 1'b0;
        host_if.wr_addr      = '0;
        host_if.wr_data      = 24'h0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk_clk);
        check_value("rst_dout", dout, 1'b0);
        check_value("rst_busy", host_if.busy, 1'b0);
        check_value("rst_done", host_if.done, 1'b0);
        reset_reset_n = 1'b1;
        idle(3);

        // Frame with an untouched buffer: all '0' bits
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        idle(510);

        // Single frame with explicit pixels and done latency from LOAD entry
        cycle(1'b0, 1'b0, 1'b1, 0, 24'h800001);
        cycle(1'b0, 1'b0, 1'b1, 1, 24'h000000);
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        lat = 0;
        while (host_if.done !== 1'b1 && lat < 700) begin
            idle(1);
            lat++;
        end
        check_value("done_lat", lat, LAST_T + 1);
        idle(10);

        // Two starts during SEND merge into exactly one extra frame
        d0 = n_done_seen;
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        idle(50);
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        idle(30);
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        idle(1100);
        check_value("pending_frames", n_done_seen - d0, 2);
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        idle(510);
        check_value("third_frame", n_done_seen - d0, 3);

        // Mid-frame writes: pixel1 during pixel0 bit 5, pixel0 after it was loaded
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        idle(54);
        cycle(1'b0, 1'b0, 1'b1, 1, 24'hFFFFFF);
        idle(250);
        cycle(1'b0, 1'b0, 1'b1, 0, 24'h5A3C96);
        idle(250);
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        idle(510);

        // Auto refresh, cleared mid-frame
        d0 = n_done_seen;
        for (int i = 0; i < 1300; i++) cycle(1'b0, 1'b1, 1'b0, 0, 24'h0);
        idle(600);
        check_value("auto_frames", n_done_seen - d0, 3);

        // Async reset at pixel1 bit 10
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        idle(343);
        check_value("pre_rst_dout", dout, exp_dout());
        #2;
        reset_reset_n = 1'b0;
        #1;
        check_value("rst_mid_dout", dout, 1'b0);
        check_value("rst_mid_busy", host_if.busy, 1'b0);
        model_reset();
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        idle(30);
        cycle(1'b1, 1'b0, 1'b0, 0, 24'h0);
        idle(510);

        // Random traffic
        ar = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) ar = ~ar;
            cycle(($urandom_range(0, 199) == 0), ar, ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, NL - 1)), 24'($urandom));
        end
        idle(1100);
        check_value("final_idle", host_if.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
